// File: rtl/half_adder_stim_checker.sv
// -----------------------------------------------------------------------------
// half_adder_stim_checker
//
// Stimulus sequencer and response checker for a half_adder. A run drives the
// four input vectors 00, 01, 10, 11 (REPEAT times over). Each vector is held
// for SETTLE_CYCLES cycles and then checked for one more cycle. sum/carry are
// compared against a^b / a&b, and mismatching vectors are counted.
//
// Optional build macro: HA_CHK_FAIL_CAPTURE_EN
//   defined   -> fail_vec/fail_valid latch {a,b,sum,carry} of the first
//                mismatching check of a run
//   undefined -> fail_vec/fail_valid are tied to zero (ports kept)
//
// Parameters
//   SETTLE_CYCLES  hold cycles per vector before the check cycle (0 acts as 1)
//   REPEAT         full 4-vector passes per run (minimum 1)
//   ERR_W          width of the saturating mismatch counter
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        begin a run (honoured only in IDLE or DONE)
//   a, b         stimulus to the half_adder
//   sum, carry   response from the half_adder
//   busy         run in progress (SETTLE or CHECK)
//   done         run finished
//   pass         done with zero mismatches
//   err_count    saturating mismatch count
//   vec_idx      index of the vector currently driven
//   fail_vec     {a,b,sum,carry} of the first failing check
//   fail_valid   fail_vec holds a capture
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | after reset, waiting for start
// SETTLE | vector driven, waiting for the half_adder outputs to settle
// CHECK  | sum/carry sampled at the edge that ends this state
// DONE   | run finished; done/pass held until start or reset
// -----------------------------------------------------------------------------
module half_adder_stim_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int REPEAT        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx,
  output logic [3:0]       fail_vec,
  output logic             fail_valid
);

  // Degenerate parameter values are clamped rather than rejected.
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int REP_EFF    = (REPEAT < 1) ? 1 : REPEAT;
  localparam int SW         = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam int PW         = (REP_EFF > 1) ? $clog2(REP_EFF) : 1;

  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_EFF - 1);
  localparam logic [PW-1:0]    PASS_LAST   = PW'(REP_EFF - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]       state_q,    state_d;
  logic [1:0]       vec_q,      vec_d;
  logic [SW-1:0]    settle_q,   settle_d;
  logic [PW-1:0]    pass_cnt_q, pass_cnt_d;
  logic [ERR_W-1:0] err_q,      err_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             pass_q,     pass_d;

`ifdef HA_CHK_FAIL_CAPTURE_EN
  logic [3:0]       fvec_q,     fvec_d;
  logic             fval_q,     fval_d;
`endif

  logic exp_sum;
  logic exp_carry;
  logic mismatch;
  logic last_check;

  assign exp_sum    = vec_q[1] ^ vec_q[0];
  assign exp_carry  = vec_q[1] & vec_q[0];
  // Either bit wrong counts as a single mismatching vector.
  assign mismatch   = (sum != exp_sum) || (carry != exp_carry);
  assign last_check = (vec_q == 2'd3) && (pass_cnt_q == PASS_LAST);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    pass_cnt_d = pass_cnt_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
`ifdef HA_CHK_FAIL_CAPTURE_EN
    fvec_d     = fvec_q;
    fval_d     = fval_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_SETTLE;
          vec_d      = 2'd0;
          settle_d   = '0;
          pass_cnt_d = '0;
          err_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
`ifdef HA_CHK_FAIL_CAPTURE_EN
          fvec_d     = 4'd0;
          fval_d     = 1'b0;
`endif
        end
      end

      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_CHECK;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      ST_CHECK: begin
        if (mismatch && (err_q != ERR_MAX)) begin
          err_d = err_q + 1'b1;
        end
`ifdef HA_CHK_FAIL_CAPTURE_EN
        if (mismatch && !fval_q) begin
          fvec_d = {vec_q[1], vec_q[0], sum, carry};
          fval_d = 1'b1;
        end
`endif
        if (last_check) begin
          // a/b stay at 11 in DONE; vec_idx is not advanced.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Include this final check's result in the pass verdict.
          pass_d  = (err_q == '0) && !mismatch;
        end else begin
          state_d  = ST_SETTLE;
          vec_d    = vec_q + 2'd1;
          settle_d = '0;
          if (vec_q == 2'd3) begin
            pass_cnt_d = pass_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= 2'd0;
      settle_q   <= '0;
      pass_cnt_q <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      settle_q   <= settle_d;
      pass_cnt_q <= pass_cnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

`ifdef HA_CHK_FAIL_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fvec_q <= 4'd0;
      fval_q <= 1'b0;
    end else begin
      fvec_q <= fvec_d;
      fval_q <= fval_d;
    end
  end

  assign fail_vec   = fvec_q;
  assign fail_valid = fval_q;
`else
  assign fail_vec   = 4'd0;
  assign fail_valid = 1'b0;
`endif

  // a/b come straight from the registered vector index.
  assign a         = vec_q[1];
  assign b         = vec_q[0];
  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_half_adder_stim_checker.sv
module tb_half_adder_stim_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [3:0] sflip;
  logic [3:0] cflip;

  // Instance 0: defaults. Instance 1: ERR_W=2, REPEAT=3, SETTLE_CYCLES=0.
  logic       a0, b0, sum0, carry0, busy0, done0, pass0, fval0;
  logic [7:0] err0;
  logic [1:0] vec0;
  logic [3:0] fv0;
  logic       a1, b1, sum1, carry1, busy1, done1, pass1, fval1;
  logic [1:0] err1;
  logic [1:0] vec1;
  logic [3:0] fv1;

  // Faulty half adders: per-vector flip masks on sum and carry.
  assign sum0   = (a0 ^ b0) ^ sflip[{a0, b0}];
  assign carry0 = (a0 & b0) ^ cflip[{a0, b0}];
  assign sum1   = (a1 ^ b1) ^ sflip[{a1, b1}];
  assign carry1 = (a1 & b1) ^ cflip[{a1, b1}];

  half_adder_stim_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a0), .b(b0),
    .sum(sum0), .carry(carry0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .vec_idx(vec0), .fail_vec(fv0), .fail_valid(fval0));

  half_adder_stim_checker #(.SETTLE_CYCLES(0), .REPEAT(3), .ERR_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a1), .b(b1),
    .sum(sum1), .carry(carry1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .vec_idx(vec1), .fail_vec(fv1), .fail_valid(fval1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: cycles elapsed since the accepted start edge.
  function automatic int f_per(input int i);   // cycles per vector
    return (i == 0) ? (1 + 1) : (1 + 1);       // SETTLE 1, and SETTLE 0 treated as 1
  endfunction
  function automatic int f_rep(input int i);
    return (i == 0) ? 1 : 3;
  endfunction
  function automatic int f_sat(input int i);
    return (i == 0) ? 255 : 3;
  endfunction
  function automatic int f_len(input int i);
    return 4 * f_rep(i) * f_per(i);
  endfunction

  bit         m_valid = 1'b0;
  bit         m_act [2];
  int         m_e   [2];
  logic [3:0] m_sf  [2];
  logic [3:0] m_cf  [2];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0;
        m_e[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (start && (!m_act[i] || m_e[i] >= f_len(i))) begin
          m_act[i] <= 1'b1;
          m_e[i]   <= 0;
          m_sf[i]  <= sflip;
          m_cf[i]  <= cflip;
        end else if (m_act[i] && m_e[i] < f_len(i)) begin
          m_e[i] <= m_e[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    int len, k, cnt, e_vec, e_busy, e_done, e_err, e_pass, e_fv, e_fval;
    int v, s_got, c_got;
    int g_vec, g_a, g_b, g_busy, g_done, g_err, g_pass, g_fv, g_fval;
    string tag;
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        len = f_len(i);
        e_vec = 0; e_busy = 0; e_done = 0; e_err = 0; e_pass = 0;
        e_fv = 0; e_fval = 0;
        if (m_act[i]) begin
          k      = (m_e[i] < len) ? m_e[i] / f_per(i) : 4 * f_rep(i);
          e_busy = (m_e[i] < len) ? 1 : 0;
          e_done = 1 - e_busy;
          e_vec  = e_busy ? k % 4 : 3;
          cnt = 0;
          for (int j = 0; j < k; j++) begin
            v = j % 4;
            if (m_sf[i][v] || m_cf[i][v]) begin
              cnt++;
              if (e_fval == 0) begin
                e_fval = 1;
                s_got  = ((v / 2) ^ (v % 2)) ^ int'(m_sf[i][v]);
                c_got  = ((v / 2) & (v % 2)) ^ int'(m_cf[i][v]);
                e_fv   = v * 4 + s_got * 2 + c_got;
              end
            end
          end
          e_err  = (cnt > f_sat(i)) ? f_sat(i) : cnt;
          e_pass = (e_done == 1 && e_err == 0) ? 1 : 0;
        end
`ifndef HA_CHK_FAIL_CAPTURE_EN
        e_fv = 0; e_fval = 0;
`endif
        if (i == 0) begin
          g_vec = int'(vec0); g_a = int'(a0); g_b = int'(b0); g_busy = int'(busy0);
          g_done = int'(done0); g_err = int'(err0); g_pass = int'(pass0);
          g_fv = int'(fv0); g_fval = int'(fval0);
        end else begin
          g_vec = int'(vec1); g_a = int'(a1); g_b = int'(b1); g_busy = int'(busy1);
          g_done = int'(done1); g_err = int'(err1); g_pass = int'(pass1);
          g_fv = int'(fv1); g_fval = int'(fval1);
        end
        tag = $sformatf("u%0d", i);
        chk({tag, ".vec_idx"},    g_vec,  e_vec);
        chk({tag, ".a"},          g_a,    e_vec / 2);
        chk({tag, ".b"},          g_b,    e_vec % 2);
        chk({tag, ".busy"},       g_busy, e_busy);
        chk({tag, ".done"},       g_done, e_done);
        chk({tag, ".err_count"},  g_err,  e_err);
        chk({tag, ".pass"},       g_pass, e_pass);
        chk({tag, ".fail_vec"},   g_fv,   e_fv);
        chk({tag, ".fail_valid"}, g_fval, e_fval);
      end
    end
  end

  // ---------------- stimulus ----------------
  int lat0, lat1;

  // Pulse start, then count cycles until each instance reports done.
  // poke >= 0 re-asserts start for one cycle at that cycle of the run.
  task automatic run(input logic [3:0] sf, input logic [3:0] cf, input int poke);
    int n;
    sflip = sf;
    cflip = cf;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    lat0 = -1;
    lat1 = -1;
    n = 0;
    while (n < 100 && (lat0 < 0 || lat1 < 0)) begin
      @(negedge clk);
      start = (n == poke) ? 1'b1 : 1'b0;
      if (done0 && lat0 < 0) lat0 = n;
      if (done1 && lat1 < 0) lat1 = n;
      n++;
    end
    start = 1'b0;
    chk("run_finished_in_budget", (lat0 >= 0 && lat1 >= 0) ? 1 : 0, 1);
  endtask

  initial begin
    int exp_fv;
    rst_n = 1'b0;
    start = 1'b0;
    sflip = 4'd0;
    cflip = 4'd0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_a", int'(a0), 0);
    chk("reset_b", int'(b0), 0);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_done", int'(done0), 0);
    chk("reset_err", int'(err0), 0);

    // Correct adder.
    run(4'b0000, 4'b0000, -1);
    chk("ok_latency_u0", lat0, 8);
    chk("ok_latency_u1", lat1, 24);
    chk("ok_pass_u0", int'(pass0), 1);
    chk("ok_err_u0", int'(err0), 0);

    // sum stuck-at-0: vectors 01 and 10 fail.
    run(4'b0110, 4'b0000, -1);
    chk("sum_sa0_err_u0", int'(err0), 2);
    chk("sum_sa0_pass_u0", int'(pass0), 0);
    chk("sum_sa0_err_u1_sat", int'(err1), 3);

    // carry stuck-at-1: vectors 00, 01, 10 fail.
    run(4'b0000, 4'b0111, -1);
    chk("carry_sa1_err_u0", int'(err0), 3);
`ifdef HA_CHK_FAIL_CAPTURE_EN
    exp_fv = 1;
`else
    exp_fv = 0;
`endif
    chk("carry_sa1_fail_vec_u0", int'(fv0), exp_fv);

    // start re-pulsed during SETTLE of vector 1 is ignored.
    run(4'b0000, 4'b0000, 2);
    chk("busy_start_latency_u0", lat0, 8);
    chk("busy_start_pass_u0", int'(pass0), 1);

    // Reset for one edge during SETTLE of vector 2.
    sflip = 4'b0000;
    cflip = 4'b0111;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_a", int'(a0), 0);
    chk("midreset_b", int'(b0), 0);
    chk("midreset_busy", int'(busy0), 0);
    chk("midreset_done", int'(done0), 0);
    chk("midreset_err", int'(err0), 0);
    chk("midreset_vec", int'(vec0), 0);
    run(4'b0000, 4'b0000, -1);
    chk("after_reset_latency_u0", lat0, 8);
    chk("after_reset_pass_u0", int'(pass0), 1);

    // Inverted adder: every check fails.
    run(4'b1111, 4'b1111, -1);
    chk("inv_err_u0", int'(err0), 4);
    chk("inv_err_u1_sat", int'(err1), 3);
    chk("inv_latency_u1", lat1, 24);
    chk("inv_pass_u1", int'(pass1), 0);

    // Random fault masks and stray start pulses.
    for (int r = 0; r < 10; r++) begin
      run(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          int'($urandom_range(0, 9)) - 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
